mux2_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the two-input `MUX2_1` select datapath between two requesters. It grants one requester at a time and drives the mux `SEL`. Between owners it inserts one dead cycle so the gate-level select path settles. The selected data is registered with a `VALID` qualifier for downstream logic.

---
 rtl/mux2_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that drives a shared 2:1 mux select, with a
// one-cycle dead SWITCH state between owners and a registered, qualified data output.
module mux2_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_a_i,
    input  logic             req_b_i,
    input  logic [WIDTH-1:0] a_data_i,
    input  logic [WIDTH-1:0] b_data_i,
    output logic             gnt_a_o,
    output logic             gnt_b_o,
    output logic             sel_o,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, SWITCH} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;       // 0 = A, 1 = B
    logic             target_q, target_d;   // 0 = A, 1 = B
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             sel_q, sel_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;

    logic owner_is_b;
    logic own_req;
    logic other_req;
    logic target_req;

    assign owner_is_b = (state_q == GRANT_B);
    assign own_req    = owner_is_b ? req_b_i : req_a_i;
    assign other_req  = owner_is_b ? req_a_i : req_b_i;
    assign target_req = target_q ? req_b_i : req_a_i;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        target_d   = target_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the path last wins.
                if (req_a_i && (!req_b_i || last_q)) begin
                    state_d    = GRANT_A;
                    sel_d      = 1'b0;
                    hold_cnt_d = HOLD_ONE;
                    last_d     = 1'b0;
                end else if (req_b_i) begin
                    state_d    = GRANT_B;
                    sel_d      = 1'b1;
                    hold_cnt_d = HOLD_ONE;
                    last_d     = 1'b1;
                end
            end
            GRANT_A, GRANT_B: begin
                if ((!own_req || hold_cnt_q == HOLD_MAX) && other_req) begin
                    state_d  = SWITCH;
                    target_d = ~owner_is_b;
                    sel_d    = ~owner_is_b;
                end else if (!own_req) begin
                    state_d = IDLE;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            SWITCH: begin
                if (target_req) begin
                    state_d    = target_q ? GRANT_B : GRANT_A;
                    hold_cnt_d = HOLD_ONE;
                    last_d     = target_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_a_d = (state_d == GRANT_A);
        gnt_b_d = (state_d == GRANT_B);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            target_q   <= 1'b0;
            hold_cnt_q <= '0;
            sel_q      <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            out_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            target_q   <= target_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            // Data path samples with the select and grant already on the flops.
            if (gnt_a_q || gnt_b_q) begin
                out_q <= sel_q ? b_data_i : a_data_i;
            end
            valid_q <= gnt_a_q | gnt_b_q;
        end
    end

    assign gnt_a_o = gnt_a_q;
    assign gnt_b_o = gnt_b_q;
    assign sel_o   = sel_q;
    assign out_o   = out_q;
    assign valid_o = valid_q;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed and randomized bench for mux2_rr_arbiter, checked against an
// owner/pending-handover model of the arbitration rules.
module tb_mux2_rr_arbiter;
    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_a, req_b;
    logic [WIDTH-1:0] a_data, b_data;
    logic             gnt_a, gnt_b, sel, valid;
    logic [WIDTH-1:0] out;

    int checks = 0;
    int errors = 0;

    // Model: who owns the path (-1 none), who is waiting in the dead cycle (-1 none).
    int               m_owner, m_pend, m_run, m_last, m_sel, m_valid;
    logic [WIDTH-1:0] m_out;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_a_i (req_a),
        .req_b_i (req_b),
        .a_data_i(a_data),
        .b_data_i(b_data),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b),
        .sel_o   (sel),
        .out_o   (out),
        .valid_o (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_pend = -1; m_run = 0; m_last = 1;
        m_sel = 0; m_out = '0; m_valid = 0;
    endtask

    task automatic model_edge();
        int mine, other, pick;
        if (m_owner >= 0) m_out = (m_sel != 0) ? b_data : a_data;
        m_valid = (m_owner >= 0) ? 1 : 0;
        if (m_pend >= 0) begin
            if ((m_pend == 1) ? req_b : req_a) begin
                m_owner = m_pend; m_run = 1; m_last = m_pend;
            end
            m_pend = -1;
        end else if (m_owner < 0) begin
            if (req_a || req_b) begin
                pick = (req_a && req_b) ? 1 - m_last : (req_a ? 0 : 1);
                m_owner = pick; m_sel = pick; m_run = 1; m_last = pick;
            end
        end else begin
            mine  = (m_owner == 1) ? int'(req_b) : int'(req_a);
            other = (m_owner == 1) ? int'(req_a) : int'(req_b);
            if ((mine == 0 || m_run >= MAX_HOLD) && other != 0) begin
                m_pend = 1 - m_owner; m_sel = m_pend; m_owner = -1;
            end else if (mine == 0) begin
                m_owner = -1;
            end else if (m_run < MAX_HOLD) begin
                m_run++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".gnt_a"}, 32'(gnt_a), 32'(m_owner == 0));
        check({tag, ".gnt_b"}, 32'(gnt_b), 32'(m_owner == 1));
        check({tag, ".sel"},   32'(sel),   32'(m_sel));
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".out"},   32'(out),   32'(m_out));
        check({tag, ".excl"},  32'(gnt_a & gnt_b), 32'(0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
        $display("%0t %s req=%b%b gnt=%b%b sel=%b out=%h valid=%b", $time, tag,
                 req_a, req_b, gnt_a, gnt_b, sel, out, valid);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        logic [3:0] pat;
        rst_n = 1'b0; req_a = 0; req_b = 0; a_data = '0; b_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // Single requester A with data 1,0,1,1
        pat = 4'b1011;
        req_a = 1;
        for (int i = 0; i < 4; i++) begin
            a_data = WIDTH'(pat[3-i]);
            b_data = 4'hF;
            step("single_a");
        end
        req_a = 0;
        steps("single_a_idle", 3);

        // Handover A -> B
        req_a = 1; a_data = 4'h5; b_data = 4'hA;
        steps("handover_a", 2);
        req_a = 0; req_b = 1;
        steps("handover_sw", 4);
        req_b = 0;
        steps("handover_idle", 2);

        // Fairness: both held
        req_a = 1; req_b = 1; a_data = 4'h3; b_data = 4'hC;
        steps("fair", 20);
        req_a = 0; req_b = 0;
        steps("fair_idle", 3);

        // Saturation: A alone past MAX_HOLD, then B arrives
        req_a = 1;
        for (int i = 0; i < 10; i++) begin
            step("sat");
            check("sat.gnt_a_const", 32'(gnt_a), 32'(1));
        end
        req_b = 1;
        steps("sat_rot", 3);
        req_a = 0; req_b = 0;
        steps("sat_idle", 4);

        // Aborted switch: B drops while in the dead cycle
        req_a = 1;
        steps("abort_a", 2);
        req_a = 0; req_b = 1;
        step("abort_sw");
        req_b = 0;
        steps("abort_idle", 3);
        check("abort.sel_held", 32'(sel), 32'(1));

        // Asynchronous reset in the middle of a B grant with hold count 3
        req_b = 1; b_data = 4'h9;
        steps("rst_b", 3);
        check("rst.model_run", 32'(m_run), 32'(3));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        req_a = 1; req_b = 1;
        @(negedge clk) rst_n = 1'b1;
        step("post_rst");
        check("post_rst.gnt_a", 32'(gnt_a), 32'(1));
        req_a = 0; req_b = 0;
        steps("post_rst_idle", 4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req_a  = ($urandom_range(0, 3) != 0);
            req_b  = ($urandom_range(0, 3) != 0);
            a_data = WIDTH'($urandom);
            b_data = WIDTH'($urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
